// File: rtl/sram_arbiter.sv
// Three-port arbiter for the shared asynchronous 8-bit SRAM: fixed priority 0 > 1 > 2
// with a starvation guard for the CPU, and CE/OE/WE strobe sequencing per access.
module sram_arbiter #(
   parameter int AW      = 19,
   parameter int DW      = 8,
   parameter int ACC_CYC = 2,
   parameter int MAXWAIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [2:0]    req,
   input  logic [2:0]    we,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [AW-1:0] addr2,
   input  logic [DW-1:0] wdat0,
   input  logic [DW-1:0] wdat1,
   input  logic [DW-1:0] wdat2,
   output logic [2:0]    ack,
   output logic [DW-1:0] rdat,
   output logic [2:0]    gnt,
   output logic [AW-1:0] SRAM_A,
   output logic [DW-1:0] SRAM_DO,
   output logic          SRAM_DOE,
   input  logic [DW-1:0] SRAM_DI,
   output logic          SRAM_CE_N,
   output logic          SRAM_OE_N,
   output logic          SRAM_WE_N
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t        state_r, state_s;
   logic [2:0]    win_s;
   logic [AW-1:0] addr_s;
   logic [DW-1:0] wdat_s;
   logic          we_s, op_s, start_s, done_s;
   logic          op_we_r;
   logic [3:0]    wait_r, starve_r;
   logic [2:0]    ack_r, gnt_r;
   logic [DW-1:0] rdat_r, do_r;
   logic [AW-1:0] a_r;
   logic          doe_r, ce_n_r, oe_n_r, we_n_r;

   // Winner selection; the starvation guard only matters when video and CPU both ask
   always_comb begin
      win_s = 3'b000;
      if (req[0]) begin
         win_s = 3'b001;
      end else if (req[1] && req[2] && (starve_r == 4'(MAXWAIT))) begin
         win_s = 3'b100;
      end else if (req[1]) begin
         win_s = 3'b010;
      end else if (req[2]) begin
         win_s = 3'b100;
      end else begin
         win_s = 3'b000;
      end
   end

   // Request fields of the winning port
   always_comb begin
      addr_s = addr0;
      wdat_s = wdat0;
      case (win_s)
         3'b010: begin
            addr_s = addr1;
            wdat_s = wdat1;
         end
         3'b100: begin
            addr_s = addr2;
            wdat_s = wdat2;
         end
         default: begin
            addr_s = addr0;
            wdat_s = wdat0;
         end
      endcase
   end

   assign we_s    = |(we & win_s);
   assign start_s = (state_r == IDLE) && (req != 3'b000);
   assign done_s  = (state_r == ACCESS) && (wait_r == 4'd0);
   assign op_s    = start_s ? we_s : op_we_r;

   // Access sequencer next state
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               state_s = SETUP;
            end else begin
               state_s = IDLE;
            end
         end
         SETUP:  state_s = ACCESS;
         ACCESS: begin
            if (done_s) begin
               state_s = HOLD;
            end else begin
               state_s = ACCESS;
            end
         end
         HOLD:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Sequencer state, latched request and starvation bookkeeping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= IDLE;
         op_we_r  <= 1'b0;
         wait_r   <= 4'd0;
         starve_r <= 4'd0;
         a_r      <= '0;
         do_r     <= '0;
      end else begin
         state_r <= state_s;
         op_we_r <= op_s;
         if (state_r == SETUP) begin
            wait_r <= 4'(ACC_CYC - 1);
         end else if ((state_r == ACCESS) && (wait_r != 4'd0)) begin
            wait_r <= wait_r - 4'd1;
         end else begin
            wait_r <= wait_r;
         end
         if (start_s) begin
            a_r  <= addr_s;
            do_r <= wdat_s;
            if (win_s[2]) begin
               starve_r <= 4'd0;
            end else if (win_s[1] && req[2] && (starve_r < 4'(MAXWAIT))) begin
               starve_r <= starve_r + 4'd1;
            end else begin
               starve_r <= starve_r;
            end
         end
      end
   end

   // Strobes are computed from the next state so each pin reflects the state it belongs to
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ce_n_r <= 1'b1;
         oe_n_r <= 1'b1;
         we_n_r <= 1'b1;
         doe_r  <= 1'b0;
         gnt_r  <= 3'b000;
         ack_r  <= 3'b000;
         rdat_r <= '0;
      end else begin
         ce_n_r <= (state_s == IDLE);
         oe_n_r <= (state_s == IDLE) || op_s;
         we_n_r <= !((state_s == ACCESS) && op_s);
         doe_r  <= (state_s != IDLE) && op_s;
         if (state_s == IDLE) begin
            gnt_r <= 3'b000;
         end else if (start_s) begin
            gnt_r <= win_s;
         end else begin
            gnt_r <= gnt_r;
         end
         ack_r <= done_s ? gnt_r : 3'b000;
         // Data is stable under OE by the last ACCESS cycle, so rdat is valid alongside ack
         if (done_s && !op_we_r) begin
            rdat_r <= SRAM_DI;
         end
      end
   end

   assign ack       = ack_r;
   assign gnt       = gnt_r;
   assign rdat      = rdat_r;
   assign SRAM_A    = a_r;
   assign SRAM_DO   = do_r;
   assign SRAM_DOE  = doe_r;
   assign SRAM_CE_N = ce_n_r;
   assign SRAM_OE_N = oe_n_r;
   assign SRAM_WE_N = we_n_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a cycle-count reference model predicts grants, pins and acks;
// a negedge monitor compares pins every cycle and pops expected acks when the DUT pulses ack.
module tb_sram_arbiter;
   localparam int AW = 19;
   localparam int DW = 8;
   localparam int ACC = 2;
   localparam int MAXW = 4;

   logic          clk, rst;
   logic [2:0]    req, we, ack, gnt;
   logic [AW-1:0] addr0, addr1, addr2, sram_a;
   logic [DW-1:0] wdat0, wdat1, wdat2, rdat, sram_do, sram_di;
   logic          sram_doe, ce_n, oe_n, we_n;

   sram_arbiter #(.AW(AW), .DW(DW), .ACC_CYC(ACC), .MAXWAIT(MAXW)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we),
      .addr0(addr0), .addr1(addr1), .addr2(addr2),
      .wdat0(wdat0), .wdat1(wdat1), .wdat2(wdat2),
      .ack(ack), .rdat(rdat), .gnt(gnt),
      .SRAM_A(sram_a), .SRAM_DO(sram_do), .SRAM_DOE(sram_doe), .SRAM_DI(sram_di),
      .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n)
   );

   typedef struct {
      int         port;
      int         ack_cyc;
      bit         rd;
      logic [7:0] data;
   } exp_t;

   exp_t       sb_q[$];
   int         ack_log[$];
   logic [7:0] ref_mem[int];
   logic [7:0] sram_mem[int];
   int         checks = 0, passes = 0;
   int         cyc = 0, next_dec = 0, starve = 0;
   bit         act_valid = 1'b0, act_we = 1'b0;
   int         act_port = 0, act_start = 0;
   logic [18:0] act_addr = '0;
   logic [7:0] act_wdat = '0, act_rdata = '0, last_rdat = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] init_pat(input int a);
      return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
   endfunction

   function automatic logic [7:0] ref_rd(input int a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_pat(a);
   endfunction

   function automatic logic [7:0] sram_rd(input int a);
      if (sram_mem.exists(a)) return sram_mem[a];
      return init_pat(a);
   endfunction

   function automatic int pack_q(input int q[$]);
      int c = 0;
      foreach (q[i]) c = c * 4 + q[i] + 1;
      return c;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
   endtask

   // SRAM pin model: writes on WE low, drives read data while OE is low
   initial begin
      sram_di = 8'h00;
      forever begin
         @(negedge clk);
         if (!ce_n && !we_n && sram_doe) sram_mem[int'(sram_a)] = sram_do;
         sram_di = (!ce_n && !oe_n) ? sram_rd(int'(sram_a)) : 8'h00;
      end
   end

   // Reference model: one decision per free IDLE cycle, each access lasting ACC+3 cycles
   initial begin
      int w;
      exp_t e;
      logic [18:0] a;
      logic [7:0] d;
      bit wr;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst) begin
            act_valid = 1'b0;
            starve = 0;
            next_dec = cyc;
         end else if (cyc - 1 == next_dec) begin
            if (req != 3'b000) begin
               if (req[0]) w = 0;
               else if (req[1] && req[2] && starve == MAXW) w = 2;
               else if (req[1]) w = 1;
               else w = 2;
               if (w == 1 && req[2]) starve = (starve < MAXW) ? starve + 1 : starve;
               else if (w == 2) starve = 0;
               case (w)
                  0: begin a = addr0; d = wdat0; wr = we[0]; end
                  1: begin a = addr1; d = wdat1; wr = we[1]; end
                  default: begin a = addr2; d = wdat2; wr = we[2]; end
               endcase
               act_valid = 1'b1; act_port = w; act_start = cyc;
               act_we = wr; act_addr = a; act_wdat = d;
               e.port = w; e.ack_cyc = cyc + ACC + 1; e.rd = !wr;
               if (wr) begin
                  ref_mem[int'(a)] = d;
                  e.data = 8'h00;
               end else begin
                  e.data = ref_rd(int'(a));
               end
               act_rdata = e.data;
               sb_q.push_back(e);
               next_dec = cyc + ACC + 2;
            end else begin
               next_dec = cyc;
            end
         end
      end
   end

   // Monitor: per-cycle pin comparison and scoreboard pop on every ack pulse
   initial begin
      int ph;
      bit active, hold;
      logic [17:0] pe, pa;
      exp_t e;
      forever begin
         @(negedge clk);
         pa = {ce_n, oe_n, we_n, sram_doe, ack, gnt, rdat};
         if (!rst) begin
            sb_q.delete();
            last_rdat = 8'h00;
            chk("reset_pins", 64'(pa), 64'({3'b111, 1'b0, 3'b000, 3'b000, 8'h00}));
            chk("reset_addr_data", 64'({sram_a, sram_do}), 64'd0);
         end else begin
            ph = cyc - act_start;
            active = act_valid && ph >= 0 && ph <= ACC + 1;
            hold = active && ph == ACC + 1;
            if (hold && !act_we) last_rdat = act_rdata;
            pe = {!active, !(active && !act_we), !(active && act_we && ph >= 1 && ph <= ACC),
                  active && act_we, hold ? 3'(1 << act_port) : 3'b000,
                  active ? 3'(1 << act_port) : 3'b000, last_rdat};
            chk("pins", 64'(pa), 64'(pe));
            if (active) chk("addr_data", 64'({sram_a, sram_do}), 64'({act_addr, act_wdat}));
            while (sb_q.size() > 0 && sb_q[0].ack_cyc < cyc) begin
               e = sb_q.pop_front();
               chk("ack_missing", 64'(0), 64'(1 << e.port));
            end
            if (ack != 3'b000) begin
               if (sb_q.size() == 0) begin
                  chk("ack_unexpected", 64'(ack), 64'd0);
               end else begin
                  e = sb_q.pop_front();
                  chk("ack_port", 64'(ack), 64'(1 << e.port));
                  chk("ack_cycle", 64'(cyc), 64'(e.ack_cyc));
                  if (e.rd) chk("ack_rdat", 64'(rdat), 64'(e.data));
                  ack_log.push_back(e.port);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (req != 3'b000 && n < budget) begin
         tick();
         req = req & ~ack;
         n++;
      end
      chk("drain_req", 64'(req), 64'd0);
      tick();
      tick();
   endtask

   task automatic set_port(input int p, input logic w, input logic [18:0] a, input logic [7:0] d);
      case (p)
         0: begin we[0] = w; addr0 = a; wdat0 = d; end
         1: begin we[1] = w; addr1 = a; wdat1 = d; end
         default: begin we[2] = w; addr2 = a; wdat2 = d; end
      endcase
   endtask

   // Stimulus
   initial begin
      int exp_order[$];
      int n;
      bit got2;
      logic [2:0] waiting;
      rst = 1'b0; req = 3'b000; we = 3'b000;
      addr0 = 19'h00001; addr1 = 19'h00002; addr2 = 19'h00003;
      wdat0 = 8'h00; wdat1 = 8'h00; wdat2 = 8'h00;

      // Reset with all requests asserted, then priority order 0, 1, 2
      req = 3'b111;
      repeat (3) tick();
      ack_log.delete();
      rst = 1'b1;
      drain(60);
      exp_order = '{0, 1, 2};
      chk("prio_order", 64'(pack_q(ack_log)), 64'(pack_q(exp_order)));

      // CPU read of a preloaded location
      sram_mem[32'h1234] = 8'hA5;
      ref_mem[32'h1234] = 8'hA5;
      set_port(2, 1'b0, 19'h01234, 8'h00);
      req = 3'b100;
      drain(20);
      chk("cpu_read_rdat", 64'(rdat), 64'h A5);

      // Loader write leaves rdat alone
      set_port(0, 1'b1, 19'h00010, 8'h3C);
      req = 3'b001;
      drain(20);
      chk("loader_write_mem", 64'(sram_rd(32'h10)), 64'h3C);
      chk("loader_write_rdat", 64'(rdat), 64'hA5);

      // Starvation guard: video held continuously against a waiting CPU
      we = 3'b000;
      ack_log.delete();
      got2 = 1'b0;
      req = 3'b110;
      n = 0;
      while (req != 3'b000 && n < 200) begin
         tick();
         if (ack[2]) begin
            req[2] = 1'b0;
            got2 = 1'b1;
         end else if (ack[1] && got2) begin
            req[1] = 1'b0;
         end
         n++;
      end
      tick();
      tick();
      exp_order = '{1, 1, 1, 1, 2, 1};
      chk("starve_order", 64'(pack_q(ack_log)), 64'(pack_q(exp_order)));

      // Reset during the write strobe, then the re-requested write completes
      ack_log.delete();
      set_port(0, 1'b1, 19'h00020, 8'h77);
      req = 3'b001;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (we_n == 1'b0) break;
      end
      chk("we_strobe_seen", 64'(we_n), 64'd0);
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      drain(30);
      chk("reset_rewrite_mem", 64'(sram_rd(32'h20)), 64'h77);
      exp_order = '{0};
      chk("reset_rewrite_acks", 64'(pack_q(ack_log)), 64'(pack_q(exp_order)));

      // Random traffic with latched-field scrambling and mid-access request drops
      waiting = 3'b000;
      for (int c = 0; c < 600; c++) begin
         tick();
         waiting = waiting & ~ack;
         req = req & ~ack;
         for (int p = 0; p < 3; p++) begin
            if (gnt[p] && $urandom_range(0, 3) == 0)
               set_port(p, 1'($urandom), 19'($urandom), 8'($urandom));
            if (gnt[p] && $urandom_range(0, 15) == 0) req[p] = 1'b0;
            if (!waiting[p] && !req[p] && $urandom_range(0, 2) == 0) begin
               set_port(p, 1'($urandom), 19'($urandom_range(0, 31)), 8'($urandom));
               req[p] = 1'b1;
               waiting[p] = 1'b1;
            end
         end
      end
      n = 0;
      while (waiting != 3'b000 && n < 100) begin
         tick();
         waiting = waiting & ~ack;
         req = req & ~ack;
         n++;
      end
      chk("random_drain", 64'(waiting), 64'd0);
      tick();
      tick();
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
